// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arith/compare ops, bit-serial shifts and an
// iterative shift-add multiplier behind a start/ready/done handshake.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSrl = 3'b011;
  localparam logic [2:0] OpSlt = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSll = 3'b111;

  localparam logic [SHW-1:0] CntOne  = SHW'(1);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StMul
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_acc, w_acc_d;
  logic [WIDTH-1:0] r_mcand, w_mcand_d;
  logic [WIDTH-1:0] r_mplier, w_mplier_d;
  logic [SHW-1:0]   r_cnt, w_cnt_d;
  logic             r_shl, w_shl_d;
  logic [WIDTH-1:0] r_result, w_result_d;
  logic             r_zero, w_zero_d;
  logic             r_done, w_done_d;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_simple;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_shifted;
  logic             w_fin;
  logic [WIDTH-1:0] w_fin_val;

  assign w_shamt = op_b[SHW-1:0];

  // Results of the ops that complete at the accept edge.
  always_comb begin
    w_simple = '0;
    unique case (alu_ctrl)
      OpAnd:   w_simple = op_a & op_b;
      OpOr:    w_simple = op_a | op_b;
      OpAdd:   w_simple = op_a + op_b;
      OpSub:   w_simple = op_a - op_b;
      OpSlt:   w_simple = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OpSll:   w_simple = op_a;
      OpSrl:   w_simple = op_a;
      OpMul:   w_simple = '0;
    endcase
  end

  assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_shifted = r_shl ? (r_acc << 1) : (r_acc >> 1);

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_cnt_d    = r_cnt;
    w_shl_d    = r_shl;
    w_fin      = 1'b0;
    w_fin_val  = '0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (alu_ctrl == OpMul) begin
            w_acc_d    = '0;
            w_mcand_d  = op_a;
            w_mplier_d = op_b;
            w_cnt_d    = CntLast;
            w_state_d  = StMul;
          end else if ((alu_ctrl == OpSll || alu_ctrl == OpSrl) && w_shamt != '0) begin
            w_shl_d   = (alu_ctrl == OpSll);
            w_acc_d   = (alu_ctrl == OpSll) ? (op_a << 1) : (op_a >> 1);
            w_cnt_d   = w_shamt - CntOne;
            w_state_d = StShift;
          end else begin
            w_fin     = 1'b1;
            w_fin_val = w_simple;
          end
        end
      end
      StShift: begin
        if (r_cnt == '0) begin
          w_fin     = 1'b1;
          w_fin_val = r_acc;
          w_state_d = StIdle;
        end else begin
          w_acc_d = w_shifted;
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StMul: begin
        // The last iteration's sum goes straight to result, giving WIDTH+1 latency.
        w_acc_d    = w_sum;
        w_mcand_d  = r_mcand << 1;
        w_mplier_d = r_mplier >> 1;
        w_cnt_d    = r_cnt - CntOne;
        if (r_cnt == '0) begin
          w_fin     = 1'b1;
          w_fin_val = w_sum;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_result_d = r_result;
    w_zero_d   = r_zero;
    w_done_d   = 1'b0;
    if (w_fin) begin
      w_result_d = w_fin_val;
      w_zero_d   = (w_fin_val == '0);
      w_done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_shl    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_cnt    <= w_cnt_d;
      r_shl    <= w_shl_d;
      r_result <= w_result_d;
      r_zero   <= w_zero_d;
      r_done   <= w_done_d;
    end
  end

  assign ready  = (r_state == StIdle);
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against an arithmetic reference
// model of result, zero flag and completion latency.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] c, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [63:0] prod;
    int sh;
    sh   = int'(b % W);
    prod = 64'(a) * 64'(b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return a << sh;
      3'b011:  return a >> sh;
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return prod[W-1:0];
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] c, input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    if (c == 3'b101) return W + 1;
    if ((c == 3'b111 || c == 3'b011) && sh != 0) return sh + 1;
    return 1;
  endfunction

  // Called on a falling edge with the unit idle; returns on a falling edge, idle.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb);
    int n;
    int lat;
    logic [W-1:0] exp_r;
    exp_r = ref_result(c, a, b);
    lat   = ref_latency(c, b);
    chk({tag, "_ready_pre"}, 64'(ready), 64'd1);
    start = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 3'($urandom); op_a = $urandom; op_b = $urandom;
    @(negedge clk);
    n = 1;
    if (lat > 1) chk({tag, "_ready_busy"}, 64'(ready), 64'd0);
    while (done !== 1'b1 && n < 200) begin
      if (disturb && n == 3) begin
        start = 1'b1; alu_ctrl = 3'b010; op_a = 32'd1; op_b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_result"}, 64'(result), 64'(exp_r));
    chk({tag, "_zero"}, 64'(zero), 64'(exp_r == '0));
    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    logic [2:0] codes[8];
    logic [2:0] c;
    logic [W-1:0] a, b;
    codes = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

    rst = 1'b1; start = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);

    run_op("add_5_7", 3'b010, 32'd5, 32'd7, 1'b0);

    // SUB then SLT issued on consecutive edges.
    start = 1'b1; alu_ctrl = 3'b110; op_a = 32'h3; op_b = 32'h3;
    @(posedge clk); #1;
    alu_ctrl = 3'b100; op_a = 32'hFFFF_FFFF; op_b = 32'h1;
    @(negedge clk);
    chk("b2b_sub_done", 64'(done), 64'd1);
    chk("b2b_sub_result", 64'(result), 64'd0);
    chk("b2b_sub_zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_slt_done", 64'(done), 64'd1);
    chk("b2b_slt_result", 64'(result), 64'd1);
    chk("b2b_slt_zero", 64'(zero), 64'd0);
    @(negedge clk);
    chk("b2b_done_drop", 64'(done), 64'd0);

    run_op("sll_31", 3'b111, 32'h1, 32'd31, 1'b0);
    run_op("srl_0", 3'b011, 32'h8000_0000, 32'hFFFF_FFE0, 1'b0);
    run_op("sll_upper_b", 3'b111, 32'h0000_00F1, 32'h0000_0104, 1'b0);
    run_op("mul_neg1_3", 3'b101, 32'hFFFF_FFFF, 32'd3, 1'b0);
    run_op("mul_wrap0", 3'b101, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_op("mul_disturb", 3'b101, 32'd1234, 32'd5678, 1'b1);

    // Reset partway through a MUL must abort it silently.
    start = 1'b1; alu_ctrl = 3'b101; op_a = 32'd77; op_b = 32'd99;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_zero", 64'(zero), 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_op("add_2_2", 3'b010, 32'd2, 32'd2, 1'b0);

    for (int i = 0; i < 48; i++) begin
      c = codes[i % 8];
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = a;
      run_op("rand", c, a, b, 1'(i % 7 == 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
